id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
- Decode/issue stage of the two-stage processor; the producer side of the execute stage's input interface.
- Accepts 32-bit instructions over a valid/ready handshake, decodes them and reads an internal 8x32 register file.
- Tracks outstanding register writes with a scoreboard and drives enable_ex/src1/src2/imm/control_in to the execute stage one cycle after acceptance.
- Receives the writeback port that returns results and load data into the register file.

Parameters:
- NREG, 8, register count; address width is log2(NREG)=3.
- IMM_W, 16, instruction immediate width, sign-extended to 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction presented.
- instr  in  32  instruction word.
- instr_ready  out  1  stage can accept; transfer occurs when valid&ready at a rising edge.
- wb_en  in  1  writeback strobe.
- wb_addr  in  3  writeback register.
- wb_data  in  32  writeback value.
- enable_ex  out  1  execute-stage issue strobe.
- src1  out  32  operand 1.
- src2  out  32  operand 2 / store data.
- imm  out  32  sign-extended immediate.
- control_in  out  7  {opselect[2:0], imm_sel, operation[2:0]}.

Behaviour:
- Instruction format:
  - [31:29] opselect: 001 arith, 010 shift, 100 memory.
  - [28] imm_sel: immediate operand for arith/shift; 1=load, 0=store for memory.
  - [27:25] operation.
  - [24:22] rd, [21:19] rs1, [18:16] rs2, [15:0] imm16.
- control_in = instr[31:25] verbatim. imm = sign-extend(instr[15:0]).
- Register reads:
  - rs1 is used by every legal op.
  - rs2 is used when imm_sel=0 for arith/shift, and for stores.
  - rs1 supplies the memory base; rs2 supplies the store data.
  - Unused source outputs are driven to 0.
- Writes rd: arith, shift, load. Stores write nothing.
- Scoreboard: pending[NREG].
  - Set pending[rd] on acceptance of a writing instruction.
  - Clear pending[wb_addr] on wb_en.
  - Same-cycle clear and set of the same register: set wins.
- Stall: instr_ready=0 when instr_valid and any used source or the rd of a writing instruction is pending and not being cleared by wb_en this cycle.
- Otherwise instr_ready=1, including when instr_valid=0. instr_ready is combinational from instr, pending, wb_en and wb_addr.
- Bypass: when wb_en and wb_addr equals a used source this cycle, the source takes wb_data, not the array value.
- Register file write: regs[wb_addr]<=wb_data on wb_en.
- Latency: an instruction accepted at edge k has enable_ex=1 and valid src1/src2/imm/control_in from edge k until edge k+1. All these outputs are registered.
- Bubbles:
  - No acceptance at an edge → enable_ex=0 next cycle; src/imm/control_in hold their previous values.
  - Illegal opselect (not 001/010/100) is consumed (ready=1) as a NOP: enable_ex=0, no scoreboard change.
- Reset, asynchronous, at any time including mid-stall:
  - regs=0, pending=0, enable_ex=0, src1=src2=imm=0, control_in=0.
  - instr_ready evaluates to 1 during and after reset.
- wb_en for a non-pending register still writes the register file; clearing is a no-op.

Decomposition:
- Package id_pkg:
  - opselect constants OPS_ARITH=3'b001, OPS_SHIFT=3'b010, OPS_MEM=3'b100.
  - Field bit positions.
  - NREG/IMM_W defaults.
  - Function uses_rs2(opselect, imm_sel) and function writes_rd(opselect, imm_sel).
- Sub-module id_regfile: 8x32 array, two combinational read ports with writeback bypass, one write port, async reset.

Test Plan:
- Reset, then accept arith rd=1, rs1=0, rs2=0, imm_sel=0, op=000 → next cycle: enable_ex=1, control_in=7'b0010000, src1=src2=0, pending[1]=1.
- Accept shift imm_sel=1, rs1=2, imm16=0xFFFE → imm=0xFFFFFFFE, src2=0, control_in=7'b0101xxx.
- Issue writes r3, then present arith reading r3 → instr_ready=0 for 3 cycles and enable_ex=0. Then wb_en with wb_addr=3, wb_data=7 → accepted that same cycle, src1=7 via bypass.
- Store rs1=4, rs2=5 with r4=0x10, r5=0xAB → src1=0x10, src2=0xAB, control_in=7'b1000xxx, no pending bit set. Load rd=6 → pending[6]=1 until wb_en to r6.
- Same-cycle wb_en to r2 and acceptance of a writer with rd=2 → pending[2] remains 1.
- Assert reset during a stall with pending[3]=1 → all outputs 0, pending cleared, instr_ready=1 after reset deasserts. Illegal opselect 3'b111 → consumed, enable_ex stays 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the decode/issue stage: instruction layout, opselect
// encodings and the decode predicates used by both the hazard logic and issue.
package id_pkg;

   localparam int NREG  = 8;
   localparam int IMM_W = 16;

   localparam logic [2:0] OPS_ARITH = 3'b001;
   localparam logic [2:0] OPS_SHIFT = 3'b010;
   localparam logic [2:0] OPS_MEM   = 3'b100;

   // Field order is the bit map: opselect at [31:29] down to imm16 at [15:0].
   typedef struct packed {
      logic [2:0]  opsel;
      logic        imm_sel;
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [15:0] imm16;
   } instr_t;

   typedef struct packed {
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] imm;
      logic [6:0]  ctrl;
   } issue_t;

   function automatic logic is_legal(input logic [2:0] opsel);
      return (opsel == OPS_ARITH) || (opsel == OPS_SHIFT) || (opsel == OPS_MEM);
   endfunction

   // rs2 feeds register-register ALU ops and supplies store data.
   function automatic logic uses_rs2(input logic [2:0] opsel, input logic imm_sel);
      return is_legal(opsel) && !imm_sel;
   endfunction

   function automatic logic writes_rd(input logic [2:0] opsel, input logic imm_sel);
      return (opsel == OPS_ARITH) || (opsel == OPS_SHIFT) || ((opsel == OPS_MEM) && imm_sel);
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with two combinational read ports; a same-cycle writeback is
// forwarded to the readers so the issue stage never sees a stale value.
module id_regfile #(
   parameter int NREG = id_pkg::NREG,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_en_i,
   input  logic [AW-1:0] wb_addr_i,
   input  logic [31:0]   wb_data_i,
   input  logic [AW-1:0] ra1_i,
   input  logic [AW-1:0] ra2_i,
   output logic [31:0]   rd1_o,
   output logic [31:0]   rd2_o
);

   logic [31:0] regs_q [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wb_en_i) begin
         regs_q[wb_addr_i] <= wb_data_i;
      end
   end

   assign rd1_o = (wb_en_i && (wb_addr_i == ra1_i)) ? wb_data_i : regs_q[ra1_i];
   assign rd2_o = (wb_en_i && (wb_addr_i == ra2_i)) ? wb_data_i : regs_q[ra2_i];

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes, checks the write scoreboard, reads operands and
// registers the issue bundle for the execute stage one cycle after acceptance.
module id_issue_stage #(
   parameter int NREG  = id_pkg::NREG,
   parameter int IMM_W = id_pkg::IMM_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        wb_en,
   input  logic [2:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        enable_ex,
   output logic [31:0] src1,
   output logic [31:0] src2,
   output logic [31:0] imm,
   output logic [6:0]  control_in
);
   import id_pkg::*;

   instr_t          ins;
   logic            legal, use_rs2, wr_rd, hazard, issue;
   logic [NREG-1:0] pend_q, pend_d, clr, eff_pend;
   logic [31:0]     rd1, rd2;
   logic            en_q, en_d;
   issue_t          out_q, out_d;

   assign ins     = instr_t'(instr);
   assign legal   = is_legal(ins.opsel);
   assign use_rs2 = uses_rs2(ins.opsel, ins.imm_sel);
   assign wr_rd   = writes_rd(ins.opsel, ins.imm_sel);

   always_comb begin
      clr = '0;
      if (wb_en) clr[wb_addr] = 1'b1;
   end

   // A register being written back this cycle is already free for the reader.
   assign eff_pend = pend_q & ~clr;

   assign hazard = legal && (eff_pend[ins.rs1]
                             || (use_rs2 && eff_pend[ins.rs2])
                             || (wr_rd && eff_pend[ins.rd]));

   assign instr_ready = !(instr_valid && hazard);
   assign issue       = instr_valid && instr_ready && legal;

   id_regfile #(.NREG(NREG)) u_rf (
      .clk       (clk),
      .reset     (reset),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .ra1_i     (ins.rs1),
      .ra2_i     (ins.rs2),
      .rd1_o     (rd1),
      .rd2_o     (rd2)
   );

   // Set is applied after the clear so a same-cycle re-issue keeps rd pending.
   always_comb begin
      pend_d = eff_pend;
      en_d   = issue;
      out_d  = out_q;
      if (issue) begin
         if (wr_rd) pend_d[ins.rd] = 1'b1;
         out_d.src1 = rd1;
         out_d.src2 = use_rs2 ? rd2 : '0;
         out_d.imm  = {{(32-IMM_W){ins.imm16[IMM_W-1]}}, ins.imm16[IMM_W-1:0]};
         out_d.ctrl = {ins.opsel, ins.imm_sel, ins.op};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         en_q   <= 1'b0;
         out_q  <= '0;
      end else begin
         pend_q <= pend_d;
         en_q   <= en_d;
         out_q  <= out_d;
      end
   end

   assign enable_ex  = en_q;
   assign src1       = out_q.src1;
   assign src2       = out_q.src2;
   assign imm        = out_q.imm;
   assign control_in = out_q.ctrl;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: a reference model queues each expected issue bundle
// when the instruction is presented; a negedge monitor pops and compares it.
module tb_id_issue_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic        wb_en = 1'b0;
   logic [2:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        enable_ex;
   logic [31:0] src1, src2, imm;
   logic [6:0]  control_in;

   id_issue_stage dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .enable_ex   (enable_ex),
      .src1        (src1),
      .src2        (src2),
      .imm         (imm),
      .control_in  (control_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] im;
      logic [6:0]  c;
   } exp_t;

   exp_t        sb[$];
   exp_t        last_exp;
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mregs [8];
   logic [7:0]  mpend = '0;
   logic        exp_en = 1'b0;

   function automatic logic [31:0] mk(input logic [2:0] ops, input logic isel,
                                      input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] im);
      return {ops, isel, op, rd, rs1, rs2, im};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      mpend  = '0;
      exp_en = 1'b0;
      sb.delete();
   endtask

   // One clock of stimulus; the model decides acceptance independently of the DUT.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic we,
                        input logic [2:0] wa, input logic [31:0] wd, output logic rdy);
      logic [2:0] ops, rd, r1, r2;
      logic       isel, legal, u2, wr, haz, iss;
      logic [7:0] effp;
      exp_t       e;
      @(negedge clk);
      instr_valid = v; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
      rdy  = instr_ready;
      ops  = ins[31:29]; isel = ins[28]; rd = ins[24:22]; r1 = ins[21:19]; r2 = ins[18:16];
      legal = (ops == 3'b001) || (ops == 3'b010) || (ops == 3'b100);
      u2    = legal && !isel;
      wr    = legal && ((ops != 3'b100) || isel);
      effp  = mpend & ~(we ? (8'b1 << wa) : 8'b0);
      haz   = legal && (effp[r1] || (u2 && effp[r2]) || (wr && effp[rd]));
      iss   = v && !haz && legal;
      if (iss) begin
         e.s1 = (we && wa == r1) ? wd : mregs[r1];
         e.s2 = u2 ? ((we && wa == r2) ? wd : mregs[r2]) : 32'h0;
         e.im = {{16{ins[15]}}, ins[15:0]};
         e.c  = ins[31:25];
         sb.push_back(e);
      end
      if (we) mregs[wa] = wd;
      mpend = effp | ((iss && wr) ? (8'b1 << rd) : 8'b0);
      @(posedge clk);
      #1;
      exp_en = iss;
   endtask

   task automatic drain();
      logic r;
      for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 3'(i), mregs[i], r);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if (enable_ex !== exp_en) begin
            errors++;
            $display("FAIL enable_ex got %b want %b at %0t", enable_ex, exp_en, $time);
         end
         if (enable_ex === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_issue got ctrl %b want no issue at %0t", control_in, $time);
            end else begin
               mon_e    = sb.pop_front();
               last_exp = mon_e;
               if ({src1, src2, imm, control_in} !== {mon_e.s1, mon_e.s2, mon_e.im, mon_e.c}) begin
                  errors++;
                  $display("FAIL issue_bundle got %h %h %h %b want %h %h %h %b at %0t",
                           src1, src2, imm, control_in, mon_e.s1, mon_e.s2, mon_e.im, mon_e.c, $time);
               end
            end
         end
      end
   end

   task automatic test_reset();
      #1 reset = 1'b1;
      model_reset();
      #3;
      checks++;
      if ({enable_ex, src1, src2, imm, control_in} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b %h %h %h %b want all zero", enable_ex, src1, src2, imm, control_in);
      end
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b want 1", instr_ready);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_arith_basic();
      logic r;
      cycle(1'b1, mk(3'b001, 1'b0, 3'b000, 3'd1, 3'd0, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1 || enable_ex !== 1'b1 || control_in !== 7'b0010000) begin
         errors++;
         $display("FAIL arith_issue got rdy %b en %b ctrl %b want 1 1 0010000", r, enable_ex, control_in);
      end
      cycle(1'b1, mk(3'b001, 1'b0, 3'b001, 3'd7, 3'd1, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b0) begin
         errors++;
         $display("FAIL arith_pending_r1 got rdy %b want 0", r);
      end
      cycle(1'b1, mk(3'b001, 1'b0, 3'b001, 3'd7, 3'd1, 3'd0, 16'h0), 1'b1, 3'd1, 32'h55, r);
      checks++;
      if (r !== 1'b1 || src1 !== 32'h55) begin
         errors++;
         $display("FAIL arith_wb_release got rdy %b src1 %h want 1 00000055", r, src1);
      end
      drain();
   endtask

   task automatic test_shift_imm();
      logic r;
      cycle(1'b0, 32'h0, 1'b1, 3'd2, 32'h1234, r);
      cycle(1'b1, mk(3'b010, 1'b1, 3'b011, 3'd0, 3'd2, 3'd5, 16'hFFFE), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1 || imm !== 32'hFFFFFFFE || src2 !== 32'h0 || src1 !== 32'h1234
          || control_in !== 7'b0101011) begin
         errors++;
         $display("FAIL shift_imm got rdy %b imm %h src1 %h src2 %h ctrl %b want 1 fffffffe 00001234 0 0101011",
                  r, imm, src1, src2, control_in);
      end
      drain();
   endtask

   task automatic test_stall();
      logic r;
      cycle(1'b1, mk(3'b001, 1'b1, 3'b000, 3'd3, 3'd0, 3'd0, 16'h0001), 1'b0, 3'd0, 32'h0, r);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, mk(3'b001, 1'b0, 3'b010, 3'd4, 3'd3, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
         checks++;
         if (r !== 1'b0 || enable_ex !== 1'b0) begin
            errors++;
            $display("FAIL stall_%0d got rdy %b en %b want 0 0", i, r, enable_ex);
         end
      end
      cycle(1'b1, mk(3'b001, 1'b0, 3'b010, 3'd4, 3'd3, 3'd0, 16'h0), 1'b1, 3'd3, 32'h7, r);
      checks++;
      if (r !== 1'b1 || enable_ex !== 1'b1 || src1 !== 32'h7) begin
         errors++;
         $display("FAIL stall_bypass got rdy %b en %b src1 %h want 1 1 00000007", r, enable_ex, src1);
      end
      drain();
   endtask

   task automatic test_store_load();
      logic r;
      cycle(1'b0, 32'h0, 1'b1, 3'd4, 32'h10, r);
      cycle(1'b0, 32'h0, 1'b1, 3'd5, 32'hAB, r);
      cycle(1'b1, mk(3'b100, 1'b0, 3'b010, 3'd4, 3'd4, 3'd5, 16'h0008), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1 || src1 !== 32'h10 || src2 !== 32'hAB || control_in !== 7'b1000010) begin
         errors++;
         $display("FAIL store got rdy %b src1 %h src2 %h ctrl %b want 1 00000010 000000ab 1000010",
                  r, src1, src2, control_in);
      end
      cycle(1'b1, mk(3'b001, 1'b0, 3'b000, 3'd1, 3'd4, 3'd5, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1) begin
         errors++;
         $display("FAIL store_no_pending got rdy %b want 1", r);
      end
      cycle(1'b1, mk(3'b100, 1'b1, 3'b000, 3'd6, 3'd4, 3'd5, 16'h0004), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1 || src2 !== 32'h0) begin
         errors++;
         $display("FAIL load got rdy %b src2 %h want 1 0", r, src2);
      end
      cycle(1'b1, mk(3'b001, 1'b1, 3'b000, 3'd0, 3'd6, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b0) begin
         errors++;
         $display("FAIL load_pending got rdy %b want 0", r);
      end
      cycle(1'b1, mk(3'b001, 1'b1, 3'b000, 3'd0, 3'd6, 3'd0, 16'h0), 1'b1, 3'd6, 32'hC0DE, r);
      checks++;
      if (r !== 1'b1 || src1 !== 32'hC0DE) begin
         errors++;
         $display("FAIL load_release got rdy %b src1 %h want 1 0000c0de", r, src1);
      end
      drain();
   endtask

   task automatic test_same_cycle();
      logic r;
      cycle(1'b1, mk(3'b001, 1'b1, 3'b000, 3'd2, 3'd0, 3'd0, 16'h0002), 1'b0, 3'd0, 32'h0, r);
      cycle(1'b1, mk(3'b001, 1'b1, 3'b001, 3'd2, 3'd0, 3'd0, 16'h0003), 1'b1, 3'd2, 32'h99, r);
      checks++;
      if (r !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_accept got rdy %b want 1", r);
      end
      cycle(1'b1, mk(3'b001, 1'b0, 3'b000, 3'd0, 3'd2, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_set_wins got rdy %b want 0", r);
      end
      cycle(1'b1, mk(3'b001, 1'b0, 3'b000, 3'd0, 3'd2, 3'd0, 16'h0), 1'b1, 3'd2, 32'h77, r);
      checks++;
      if (r !== 1'b1 || src1 !== 32'h77) begin
         errors++;
         $display("FAIL same_cycle_release got rdy %b src1 %h want 1 00000077", r, src1);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic r;
      cycle(1'b1, mk(3'b001, 1'b1, 3'b100, 3'd0, 3'd4, 3'd0, 16'h8000), 1'b0, 3'd0, 32'h0, r);
      cycle(1'b1, mk(3'b010, 1'b1, 3'b101, 3'd1, 3'd5, 3'd0, 16'h7FFF), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1 || enable_ex !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back got rdy %b en %b want 1 1", r, enable_ex);
      end
      cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (enable_ex !== 1'b0 || src1 !== last_exp.s1 || imm !== last_exp.im) begin
         errors++;
         $display("FAIL bubble_hold got en %b src1 %h imm %h want 0 %h %h",
                  enable_ex, src1, imm, last_exp.s1, last_exp.im);
      end
      drain();
   endtask

   task automatic test_illegal_and_reset();
      logic r;
      cycle(1'b1, mk(3'b001, 1'b1, 3'b000, 3'd3, 3'd0, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      cycle(1'b1, mk(3'b111, 1'b1, 3'b000, 3'd5, 3'd3, 3'd3, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1 || enable_ex !== 1'b0) begin
         errors++;
         $display("FAIL illegal_nop got rdy %b en %b want 1 0", r, enable_ex);
      end
      cycle(1'b1, mk(3'b001, 1'b1, 3'b000, 3'd5, 3'd0, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1) begin
         errors++;
         $display("FAIL illegal_no_pending got rdy %b want 1", r);
      end
      cycle(1'b1, mk(3'b001, 1'b0, 3'b000, 3'd0, 3'd3, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b0) begin
         errors++;
         $display("FAIL prereset_stall got rdy %b want 0", r);
      end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({enable_ex, src1, src2, imm, control_in} !== '0 || instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL midstall_reset got en %b %h %h %h %b rdy %b want zeros rdy 1",
                  enable_ex, src1, src2, imm, control_in, instr_ready);
      end
      instr_valid = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b1, mk(3'b001, 1'b0, 3'b000, 3'd0, 3'd3, 3'd0, 16'h0), 1'b0, 3'd0, 32'h0, r);
      checks++;
      if (r !== 1'b1 || enable_ex !== 1'b1 || src1 !== 32'h0) begin
         errors++;
         $display("FAIL postreset_accept got rdy %b en %b src1 %h want 1 1 0", r, enable_ex, src1);
      end
      cycle(1'b0, 32'h0, 1'b0, 3'd0, 32'h0, r);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_arith_basic();
      test_shift_imm();
      test_stall();
      test_store_load();
      test_same_cycle();
      test_back_to_back();
      test_illegal_and_reset();
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_issues got %0d outstanding want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
